// File: rtl/conv_ctrl.sv
`timescale 1ns/1ps
// Loop-nest sequencer for a direct 2-D convolution engine: walks f/oy/ox/c/ky/kx,
// issuing feature/weight/bias addresses per tap and a save strobe per output pixel.
module conv_ctrl #(
   parameter int          IMG_W  = 8,
   parameter int          IMG_H  = 8,
   parameter int          K      = 3,
   parameter int          IN_CH  = 1,
   parameter int          OUT_CH = 2,
   parameter logic [15:0] S_BASE = 16'h0000,
   parameter logic [15:0] W_BASE = 16'h1000,
   parameter logic [15:0] B_BASE = 16'h2000,
   parameter logic [15:0] O_BASE = 16'h3000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en_ctrl,
   output logic [15:0] s_addr,
   output logic [15:0] w_addr,
   output logic [15:0] b_addr,
   output logic [15:0] save_addr,
   output logic        en_sum,
   output logic        save,
   output logic        finish
);

   localparam int OH   = IMG_H - K + 1;
   localparam int OW   = IMG_W - K + 1;
   localparam int TAPS = IN_CH * K * K;

   localparam logic [15:0] L_K1   = 16'(K - 1);
   localparam logic [15:0] L_C1   = 16'(IN_CH - 1);
   localparam logic [15:0] L_OW1  = 16'(OW - 1);
   localparam logic [15:0] L_OH1  = 16'(OH - 1);
   localparam logic [15:0] L_F1   = 16'(OUT_CH - 1);
   localparam logic [15:0] L_TAPS = 16'(TAPS);
   // Source address steps when the kernel window wraps a row / a channel plane.
   localparam logic [15:0] L_S_ROW = 16'(IMG_W - (K - 1));
   localparam logic [15:0] L_S_CH  = 16'(IMG_H * IMG_W - (K - 1) * IMG_W - (K - 1));
   // Top-left pixel step from the end of one output row to the start of the next.
   localparam logic [15:0] L_P_ROW = 16'(IMG_W - (OW - 1));

   typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_SAVE, ST_DONE} state_t;

   state_t      r_state;
   logic [15:0] r_f, r_oy, r_ox, r_c, r_ky, r_kx;
   logic [15:0] r_pix, r_wbase;
   logic [15:0] r_s_addr, r_w_addr, r_b_addr, r_save_addr;
   logic        r_en_sum, r_save, r_finish;
   logic        w_last_tap, w_last_out;

   assign w_last_tap = (r_c == L_C1) && (r_ky == L_K1) && (r_kx == L_K1);
   assign w_last_out = (r_f == L_F1) && (r_oy == L_OH1) && (r_ox == L_OW1);

   assign s_addr    = r_s_addr;
   assign w_addr    = r_w_addr;
   assign b_addr    = r_b_addr;
   assign save_addr = r_save_addr;
   assign en_sum    = r_en_sum;
   assign save      = r_save;
   assign finish    = r_finish;

   // Registers always describe the tap/pixel currently presented; an enabled edge
   // consumes it and steps to the next one, a disabled edge only drops the strobes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_f         <= '0;
         r_oy        <= '0;
         r_ox        <= '0;
         r_c         <= '0;
         r_ky        <= '0;
         r_kx        <= '0;
         r_pix       <= '0;
         r_wbase     <= '0;
         r_s_addr    <= '0;
         r_w_addr    <= '0;
         r_b_addr    <= '0;
         r_save_addr <= '0;
         r_en_sum    <= 1'b0;
         r_save      <= 1'b0;
         r_finish    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (en_ctrl) begin
                  r_state     <= ST_MAC;
                  r_f         <= '0;
                  r_oy        <= '0;
                  r_ox        <= '0;
                  r_c         <= '0;
                  r_ky        <= '0;
                  r_kx        <= '0;
                  r_pix       <= S_BASE;
                  r_wbase     <= W_BASE;
                  r_s_addr    <= S_BASE;
                  r_w_addr    <= W_BASE;
                  r_b_addr    <= B_BASE;
                  r_save_addr <= O_BASE;
                  r_en_sum    <= 1'b1;
               end
            end
            ST_MAC: begin
               if (!en_ctrl) begin
                  r_en_sum <= 1'b0;
               end else if (w_last_tap) begin
                  r_state  <= ST_SAVE;
                  r_en_sum <= 1'b0;
                  r_save   <= 1'b1;
               end else begin
                  r_en_sum <= 1'b1;
                  r_w_addr <= r_w_addr + 16'd1;
                  if (r_kx != L_K1) begin
                     r_kx     <= r_kx + 16'd1;
                     r_s_addr <= r_s_addr + 16'd1;
                  end else begin
                     r_kx <= '0;
                     if (r_ky != L_K1) begin
                        r_ky     <= r_ky + 16'd1;
                        r_s_addr <= r_s_addr + L_S_ROW;
                     end else begin
                        r_ky     <= '0;
                        r_c      <= r_c + 16'd1;
                        r_s_addr <= r_s_addr + L_S_CH;
                     end
                  end
               end
            end
            ST_SAVE: begin
               r_save <= 1'b0;
               if (en_ctrl) begin
                  if (w_last_out) begin
                     r_state  <= ST_DONE;
                     r_finish <= 1'b1;
                  end else begin
                     r_state     <= ST_MAC;
                     r_en_sum    <= 1'b1;
                     r_c         <= '0;
                     r_ky        <= '0;
                     r_kx        <= '0;
                     r_save_addr <= r_save_addr + 16'd1;
                     if (r_ox != L_OW1) begin
                        r_ox     <= r_ox + 16'd1;
                        r_pix    <= r_pix + 16'd1;
                        r_s_addr <= r_pix + 16'd1;
                        r_w_addr <= r_wbase;
                     end else begin
                        r_ox <= '0;
                        if (r_oy != L_OH1) begin
                           r_oy     <= r_oy + 16'd1;
                           r_pix    <= r_pix + L_P_ROW;
                           r_s_addr <= r_pix + L_P_ROW;
                           r_w_addr <= r_wbase;
                        end else begin
                           r_oy     <= '0;
                           r_f      <= r_f + 16'd1;
                           r_pix    <= S_BASE;
                           r_s_addr <= S_BASE;
                           r_wbase  <= r_wbase + L_TAPS;
                           r_w_addr <= r_wbase + L_TAPS;
                           r_b_addr <= r_b_addr + 16'd1;
                        end
                     end
                  end
               end
            end
            ST_DONE: begin
               if (!en_ctrl) begin
                  r_state     <= ST_IDLE;
                  r_finish    <= 1'b0;
                  r_f         <= '0;
                  r_oy        <= '0;
                  r_ox        <= '0;
                  r_c         <= '0;
                  r_ky        <= '0;
                  r_kx        <= '0;
                  r_pix       <= '0;
                  r_wbase     <= '0;
                  r_s_addr    <= '0;
                  r_w_addr    <= '0;
                  r_b_addr    <= '0;
                  r_save_addr <= '0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_ctrl.sv
`timescale 1ns/1ps
// Bench for conv_ctrl: expected per-cycle activity comes from the loop-nest address
// formulas evaluated directly, with optional fixed or random pauses.
module tb_conv_ctrl;

   localparam int IMG_W = 8, IMG_H = 8, K = 3, IN_CH = 1, OUT_CH = 2;
   localparam int OH = IMG_H - K + 1, OW = IMG_W - K + 1;
   localparam int TAPS = IN_CH * K * K, OUTS = OUT_CH * OH * OW;
   localparam int NREC = OUTS * (TAPS + 1);
   localparam int SB = 'h0000, WB = 'h1000, BB = 'h2000, OB = 'h3000;

   logic        clk = 1'b0;
   logic        rst_n, en_ctrl;
   logic [15:0] s_addr, w_addr, b_addr, save_addr;
   logic        en_sum, save, finish;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic        sv;
      logic [15:0] s, w, b, sa;
   } rec_t;
   rec_t exp_q[$];

   conv_ctrl dut (
      .clk(clk), .reset(rst_n), .en_ctrl(en_ctrl),
      .s_addr(s_addr), .w_addr(w_addr), .b_addr(b_addr), .save_addr(save_addr),
      .en_sum(en_sum), .save(save), .finish(finish)
   );

   always #5 clk = ~clk;

   task automatic build_model();
      rec_t r;
      exp_q.delete();
      for (int f = 0; f < OUT_CH; f++)
         for (int oy = 0; oy < OH; oy++)
            for (int ox = 0; ox < OW; ox++) begin
               for (int c = 0; c < IN_CH; c++)
                  for (int ky = 0; ky < K; ky++)
                     for (int kx = 0; kx < K; kx++) begin
                        r.sv = 1'b0;
                        r.s  = 16'(SB + c * IMG_H * IMG_W + (oy + ky) * IMG_W + ox + kx);
                        r.w  = 16'(WB + f * TAPS + c * K * K + ky * K + kx);
                        r.b  = 16'(BB + f);
                        r.sa = 16'(OB + f * OH * OW + oy * OW + ox);
                        exp_q.push_back(r);
                     end
               r.sv = 1'b1;
               exp_q.push_back(r);
            end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      en_ctrl = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vectors++;
         if ({s_addr, w_addr, b_addr, save_addr, en_sum, save, finish} !== '0) begin
            miscompares++;
            $display("FAIL reset_idle cycle %0d: got s=%h w=%h b=%h sa=%h es=%b sv=%b fin=%b, want all 0",
                     i, s_addr, w_addr, b_addr, save_addr, en_sum, save, finish);
         end
      end
   endtask

   task automatic test_first_pixel();
      logic [15:0] s_tbl [9] = '{16'd0, 16'd1, 16'd2, 16'd8, 16'd9, 16'd10, 16'd16, 16'd17, 16'd18};
      en_ctrl = 1'b1;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         vectors++;
         if (en_sum !== 1'b1 || save !== 1'b0 || s_addr !== s_tbl[i] ||
             w_addr !== 16'(16'h1000 + i) || b_addr !== 16'h2000) begin
            miscompares++;
            $display("FAIL first_tap%0d: got es=%b sv=%b s=%h w=%h b=%h, want es=1 sv=0 s=%h w=%h b=2000",
                     i, en_sum, save, s_addr, w_addr, b_addr, s_tbl[i], 16'(16'h1000 + i));
         end
      end
      @(negedge clk);
      vectors++;
      if (save !== 1'b1 || en_sum !== 1'b0 || save_addr !== 16'h3000 || b_addr !== 16'h2000) begin
         miscompares++;
         $display("FAIL first_save: got sv=%b es=%b sa=%h b=%h, want sv=1 es=0 sa=3000 b=2000",
                  save, en_sum, save_addr, b_addr);
      end
      @(negedge clk);
      vectors++;
      if (en_sum !== 1'b1 || save !== 1'b0 || s_addr !== 16'd1 || w_addr !== 16'h1000) begin
         miscompares++;
         $display("FAIL second_pixel_start: got es=%b sv=%b s=%h w=%h, want es=1 sv=0 s=0001 w=1000",
                  en_sum, save, s_addr, w_addr);
      end
   endtask

   task automatic test_async_reset();
      repeat (4) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({s_addr, w_addr, b_addr, save_addr, en_sum, save, finish} !== '0) begin
         miscompares++;
         $display("FAIL async_reset: got s=%h w=%h b=%h sa=%h es=%b sv=%b fin=%b, want all 0",
                  s_addr, w_addr, b_addr, save_addr, en_sum, save, finish);
      end
      en_ctrl = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // mode 0: continuous, 1: three-cycle pause mid-MAC, 2: random pauses
   task automatic run_full(input int mode);
      int          idx = 0, cyc = 0, pauses = 0, saves = 0, fin_cyc = -1;
      bit          last_en, ok;
      logic [15:0] last_sa = '0;
      rec_t        r;
      build_model();
      @(negedge clk);
      en_ctrl = 1'b1;
      last_en = 1'b1;
      while (cyc < 3000 && fin_cyc < 0) begin
         @(negedge clk);
         cyc++;
         if (!last_en) begin
            r = exp_q[idx - 1];
            ok = en_sum === 1'b0 && save === 1'b0 && finish === 1'b0 && b_addr === r.b &&
                 (r.sv ? save_addr === r.sa : (s_addr === r.s && w_addr === r.w));
            vectors++;
            if (!ok) begin
               miscompares++;
               $display("FAIL pause_hold rec %0d: got es=%b sv=%b s=%h w=%h b=%h sa=%h, want strobes 0 s=%h w=%h b=%h sa=%h",
                        idx - 1, en_sum, save, s_addr, w_addr, b_addr, save_addr, r.s, r.w, r.b, r.sa);
            end
         end else if (idx < NREC) begin
            r = exp_q[idx];
            if (r.sv)
               ok = save === 1'b1 && en_sum === 1'b0 && finish === 1'b0 &&
                    save_addr === r.sa && b_addr === r.b;
            else
               ok = en_sum === 1'b1 && save === 1'b0 && finish === 1'b0 &&
                    s_addr === r.s && w_addr === r.w && b_addr === r.b;
            vectors++;
            if (!ok) begin
               miscompares++;
               $display("FAIL seq rec %0d: got es=%b sv=%b fin=%b s=%h w=%h b=%h sa=%h, want es=%b sv=%b s=%h w=%h b=%h sa=%h",
                        idx, en_sum, save, finish, s_addr, w_addr, b_addr, save_addr,
                        !r.sv, r.sv, r.s, r.w, r.b, r.sa);
            end
            if (save === 1'b1) begin
               saves++;
               last_sa = save_addr;
            end
            idx++;
         end else begin
            fin_cyc = cyc;
            vectors++;
            if (finish !== 1'b1 || en_sum !== 1'b0 || save !== 1'b0) begin
               miscompares++;
               $display("FAIL finish_rise: got fin=%b es=%b sv=%b, want fin=1 es=0 sv=0",
                        finish, en_sum, save);
            end
         end
         if (fin_cyc < 0) begin
            if (mode == 1)      en_ctrl = !(idx == 5 && pauses < 3);
            else if (mode == 2) en_ctrl = !(idx >= 1 && $urandom_range(0, 9) == 0);
            else                en_ctrl = 1'b1;
            if (!en_ctrl) pauses++;
            last_en = en_ctrl;
         end
      end
      vectors++;
      if (fin_cyc != NREC + 1 + pauses) begin
         miscompares++;
         $display("FAIL run_length mode %0d: finish at cycle %0d, want %0d", mode, fin_cyc, NREC + 1 + pauses);
      end
      vectors++;
      if (saves != OUTS) begin
         miscompares++;
         $display("FAIL save_count mode %0d: got %0d, want %0d", mode, saves, OUTS);
      end
      vectors++;
      if (last_sa !== 16'(OB + OUTS - 1)) begin
         miscompares++;
         $display("FAIL last_save_addr mode %0d: got %h, want %h", mode, last_sa, 16'(OB + OUTS - 1));
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vectors++;
         if (finish !== 1'b1 || en_sum !== 1'b0 || save !== 1'b0) begin
            miscompares++;
            $display("FAIL finish_hold %0d: got fin=%b es=%b sv=%b, want fin=1 es=0 sv=0", i, finish, en_sum, save);
         end
      end
      en_ctrl = 1'b0;
      @(negedge clk);
      vectors++;
      if ({s_addr, w_addr, b_addr, save_addr, en_sum, save, finish} !== '0) begin
         miscompares++;
         $display("FAIL finish_clear: got fin=%b s=%h w=%h b=%h sa=%h es=%b sv=%b, want all 0",
                  finish, s_addr, w_addr, b_addr, save_addr, en_sum, save);
      end
   endtask

   task automatic test_full_run();
      run_full(0);
   endtask

   task automatic test_pause();
      run_full(1);
   endtask

   task automatic test_random_pauses();
      run_full(2);
   endtask

   initial begin
      test_reset();
      test_first_pixel();
      test_async_reset();
      test_full_run();
      test_pause();
      test_random_pauses();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
